// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM controller slice.
// Holds the one-hot arbiter state encoding broadcast to the init, refresh,
// write and read modules, the SDRAM command codes those modules drive
// ({cs_n, ras_n, cas_n, we_n}) and the default watchdog limit.
package sdram_pkg;

  // One-hot arbiter states; 6'b00_0100 is reserved and never entered.
  typedef enum logic [5:0] {
    ST_INIT  = 6'b00_0001,
    ST_ARBIT = 6'b00_0010,
    ST_RSVD  = 6'b00_0100,
    ST_WRITE = 6'b00_1000,
    ST_READ  = 6'b01_0000,
    ST_AREF  = 6'b10_0000
  } state_e;

  // SDRAM command codes {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  // Default maximum number of cycles one granted state may last.
  localparam int unsigned WDOG_MAX_DEF = 255;

  // True for the states in which a requester owns the SDRAM bus.
  function automatic logic is_granted(input logic [5:0] s);
    return (s == ST_AREF) || (s == ST_WRITE) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/sdram_wdog.sv
// sdram_wdog: watchdog for one granted arbiter state.
// Ports:
//   clk       in  system clock
//   rstn      in  asynchronous active-low reset
//   i_clr     in  restart the count (asserted on the grant edge)
//   i_en      in  count enable (high while a granted state is active)
//   o_timeout out high during the WDOG_MAX-th cycle of the granted state
// The counter holds 0 in the first granted cycle, so o_timeout rises in the
// cycle where WDOG_MAX cycles have been spent and the arbiter leaves on that
// cycle's closing edge.
module sdram_wdog
  import sdram_pkg::*;
#(
  parameter int unsigned WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam logic [7:0] LIMIT = 8'(WDOG_MAX - 1);

  logic [7:0] r_cnt;

  // Cycle counter: restarts on grant, advances while the grant is active.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_timeout = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM bus arbiter between init, auto-refresh, write and read.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   init_end                       power-up initialisation finished (level)
//   init_/ref_/wr_/rd_ cmd/addr/bank  command buses of the four masters
//   ref_req, wr_req, rd_req        level requests, held until the grant
//   ref_end, wr_end, rd_end        one-cycle completion flags
//   wr_dq, wr_dq_oe                write data and its drive enable
//   state                          one-hot arbiter state (registered)
//   ref_en, wr_en, rd_en           one-cycle grant pulses (registered)
//   sdram_cmd/addr/bank            command bus of the granted master
//   sdram_dq_out, sdram_dq_oe      tri-state data drive
//   arb_err                        sticky watchdog timeout flag
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int unsigned WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic [1:0]  init_bank,
  input  logic        ref_req,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic        ref_end,
  input  logic        wr_end,
  input  logic        rd_end,
  input  logic [3:0]  ref_cmd,
  input  logic [11:0] ref_addr,
  input  logic [1:0]  ref_bank,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  input  logic [15:0] wr_dq,
  input  logic        wr_dq_oe,
  output logic [5:0]  state,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        arb_err
);

  state_e r_state;
  state_e w_next;
  logic   r_ref_en, r_wr_en, r_rd_en, r_arb_err;
  logic   w_ref_en, w_wr_en, w_rd_en;
  logic   w_wd_clr, w_wd_en, w_timeout, w_err_set;

  assign w_wd_en = is_granted(r_state);

  sdram_wdog #(
    .WDOG_MAX (WDOG_MAX)
  ) u_wdog (
    .clk       (clk),
    .rstn      (rstn),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_timeout (w_timeout)
  );

  // Next-state and grant decode. A matching end flag beats a simultaneous
  // timeout: the operation did finish, so no error is recorded.
  always_comb begin
    w_next    = r_state;
    w_ref_en  = 1'b0;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_wd_clr  = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (init_end) w_next = ST_ARBIT;
        else          w_next = ST_INIT;
      end
      ST_ARBIT: begin
        if (ref_req) begin
          w_next   = ST_AREF;
          w_ref_en = 1'b1;
          w_wd_clr = 1'b1;
        end else if (wr_req) begin
          w_next   = ST_WRITE;
          w_wr_en  = 1'b1;
          w_wd_clr = 1'b1;
        end else if (rd_req) begin
          w_next   = ST_READ;
          w_rd_en  = 1'b1;
          w_wd_clr = 1'b1;
        end else begin
          w_next = ST_ARBIT;
        end
      end
      ST_AREF: begin
        if (ref_end)        w_next = ST_ARBIT;
        else if (w_timeout) begin
          w_next    = ST_ARBIT;
          w_err_set = 1'b1;
        end else            w_next = ST_AREF;
      end
      ST_WRITE: begin
        if (wr_end)         w_next = ST_ARBIT;
        else if (w_timeout) begin
          w_next    = ST_ARBIT;
          w_err_set = 1'b1;
        end else            w_next = ST_WRITE;
      end
      ST_READ: begin
        if (rd_end)         w_next = ST_ARBIT;
        else if (w_timeout) begin
          w_next    = ST_ARBIT;
          w_err_set = 1'b1;
        end else            w_next = ST_READ;
      end
      // Reserved or corrupted encodings fall back to arbitration.
      default: w_next = ST_ARBIT;
    endcase
  end

  // State, grant pulses and sticky error register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_INIT;
      r_ref_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_arb_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ref_en  <= w_ref_en;
      r_wr_en   <= w_wr_en;
      r_rd_en   <= w_rd_en;
      r_arb_err <= r_arb_err | w_err_set;
    end
  end

  // SDRAM pin mux: the bus of whichever master owns the current state.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = 12'd0;
    sdram_bank = 2'd0;
    case (r_state)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
        sdram_bank = init_bank;
      end
      ST_AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
        sdram_bank = ref_bank;
      end
      ST_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = 12'd0;
        sdram_bank = 2'd0;
      end
    endcase
  end

  assign state        = r_state;
  assign ref_en       = r_ref_en;
  assign wr_en        = r_wr_en;
  assign rd_en        = r_rd_en;
  assign arb_err      = r_arb_err;
  assign sdram_dq_out = wr_dq;
  assign sdram_dq_oe  = (r_state == ST_WRITE) ? wr_dq_oe : 1'b0;

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rstn  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: init_end  in  1  power-up init complete, level, stays high.
REQ-004 SHALL have ports: init_cmd/init_addr/init_bank  in  4/12/2  init module command bus.
REQ-005 SHALL have ports: ref_req, wr_req, rd_req  in  1 each  level requests, held by requester until its enable.
REQ-006 SHALL have ports: ref_end, wr_end, rd_end  in  1 each  one-cycle end flags.
REQ-007 SHALL have ports: ref_/wr_/rd_ cmd, addr, bank  in  4/12/2 each  requester command buses.
REQ-008 SHALL have ports: wr_dq  in  16  write data; wr_dq_oe  in  1  write data valid.
REQ-009 SHALL have ports: state  out  6  one-hot arbiter state, broadcast to all sub-modules.
REQ-010 SHALL have ports: ref_en, wr_en, rd_en  out  1 each  one-cycle grant pulses.
REQ-011 SHALL have ports: sdram_cmd  out  4, sdram_addr  out  12, sdram_bank  out  2  to SDRAM pins.
REQ-012 SHALL have ports: sdram_dq_out  out  16, sdram_dq_oe  out  1  tri-state data drive.
REQ-013 SHALL have ports: arb_err  out  1  sticky watchdog timeout flag.
REQ-014 SHALL have parameter: WDOG_MAX, default 255, max cycles allowed in one granted state.

Function
REQ-015 SHALL encode states INIT=6'b00_0001, ARBIT=6'b00_0010, WRITE=6'b00_1000, READ=6'b01_0000, AREF=6'b10_0000; 6'b00_0100 reserved, never entered.
REQ-016 SHALL remain in INIT until init_end high, then enter ARBIT next cycle.
REQ-017 In ARBIT, SHALL grant by fixed priority ref_req > wr_req > rd_req, evaluated each cycle.
REQ-018 On grant, SHALL in the same edge set state to AREF/WRITE/READ and pulse the matching enable for exactly one cycle.
REQ-019 With no request in ARBIT, SHALL stay in ARBIT, all enables low.
REQ-020 SHALL return to ARBIT one cycle after the matching end flag (ref_end in AREF, wr_end in WRITE, rd_end in READ).
REQ-021 SHALL ignore end flags not matching current state.
REQ-022 Requests arriving during a granted state SHALL not preempt; they wait for ARBIT (refresh re-prioritised there).
REQ-023 Back-to-back: end flag then pending request SHALL give ARBIT for exactly one cycle, then grant.
REQ-024 sdram_cmd/addr/bank SHALL be a combinational mux on state: INIT->init bus, AREF->ref bus, WRITE->wr bus, READ->rd bus, ARBIT/other->NOP 4'b0111, addr 0, bank 0.
REQ-025 sdram_dq_out SHALL equal wr_dq; sdram_dq_oe SHALL equal wr_dq_oe only in WRITE, else 0.
REQ-026 Watchdog: 8-bit counter SHALL clear on entering a granted state, increment each cycle there; on reaching WDOG_MAX, state SHALL go to ARBIT and arb_err SHALL set.
REQ-027 arb_err SHALL clear only on reset.
REQ-028 Illegal state value SHALL recover to ARBIT next cycle.

Reset
REQ-029 On rstn low: state=INIT, all enables 0, watchdog 0, arb_err 0, so sdram_cmd=init_cmd; reset mid-grant SHALL abandon operation immediately.

Structure
REQ-030 State encodings, NOP/PRE/ACT/RD/WR/AREF command codes and WDOG_MAX default SHALL live in shared package sdram_pkg, used by init/ref/write/read modules.
REQ-031 Watchdog SHALL be a separate sub-module sdram_wdog (clear, enable, timeout out).

Verification
REQ-032 Reset, init_end high at cycle 10 -> state INIT until cycle 11, ARBIT at 11, cmd NOP.
REQ-033 ref_req, wr_req, rd_req all high in ARBIT -> ref_en pulse 1 cycle, state AREF; after ref_end -> ARBIT 1 cycle -> wr_en, WRITE.
REQ-034 In READ with rd_cmd=4'b0101, rd_addr=12'h04 -> sdram_cmd=4'b0101, sdram_addr=12'h004; wr_end pulse in READ -> ignored.
REQ-035 WRITE entered, wr_end withheld, WDOG_MAX=16 -> ARBIT after 16 cycles, arb_err=1, sticky until reset.
REQ-036 rstn low while in WRITE with wr_dq_oe=1 -> sdram_dq_oe=0, state INIT same cycle.
